// File: rtl/pmem_pkg.sv
// Shared channel-state encoding and width helpers for the program-memory arbiter.
package pmem_pkg;

   localparam int unsigned STATE_BITS = 2;

   typedef enum logic [STATE_BITS-1:0] {
      IDLE    = 2'b00,
      REQUEST = 2'b01,
      RELAY   = 2'b10,
      DRAIN   = 2'b11
   } chan_state_t;

   // Index width that stays legal when only one consumer exists.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? int'(unsigned'($clog2(n))) : 1;
   endfunction

endpackage

// File: rtl/pmem_rr_picker.sv
// Round-robin picker: first set bit of mask scanning upward from start, wrapping.
module pmem_rr_picker
   import pmem_pkg::*;
#(
   parameter int unsigned NUM_CONSUMERS = 4,
   localparam int unsigned IDX_BITS = idx_bits(NUM_CONSUMERS)
) (
   input  logic [NUM_CONSUMERS-1:0] mask,
   input  logic [IDX_BITS-1:0]      start,
   output logic [NUM_CONSUMERS-1:0] grant,
   output logic                     found
);

   logic [IDX_BITS-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
         idx = IDX_BITS'((32'(start) + i) % NUM_CONSUMERS);
         if (!found && mask[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS program-memory read channels among
// NUM_CONSUMERS fetchers, 4-phase valid/ready on both sides, all outputs registered.
module pmem_arbiter
   import pmem_pkg::*;
#(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 16,
   parameter int unsigned NUM_CONSUMERS = 4,
   parameter int unsigned NUM_CHANNELS  = 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
   output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]                 channel_busy
);

   localparam int unsigned IDX_BITS = idx_bits(NUM_CONSUMERS);

   chan_state_t                             state_q [NUM_CHANNELS];
   logic [IDX_BITS-1:0]                     owner_q [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]                 mem_valid_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_addr_q;
   logic [NUM_CONSUMERS-1:0]                cons_ready_q;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_data_q;
   logic [IDX_BITS-1:0]                     rr_ptr_q, rr_ptr_d;

   logic [NUM_CONSUMERS-1:0]               owned, eligible;
   logic [NUM_CHANNELS-1:0]                pick_found;
   logic [NUM_CHANNELS-1:0][IDX_BITS-1:0]  pick_idx;

   // A consumer still showing ready must see its valid drop before a new grant.
   always_comb begin
      owned = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (state_q[ch] == REQUEST || state_q[ch] == RELAY) begin
            owned[owner_q[ch]] = 1'b1;
         end
      end
      eligible = consumer_read_valid & ~owned & ~cons_ready_q;
   end

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
      logic [NUM_CONSUMERS-1:0] avail_in, avail_out, mask, grant;
      logic                     found;
      logic [IDX_BITS-1:0]      idx;

      // Each channel only sees consumers not taken by lower-indexed channels this cycle.
      if (ch == 0) begin : g_first
         assign avail_in = eligible;
      end else begin : g_next
         assign avail_in = g_chan[ch-1].avail_out;
      end

      assign mask      = (state_q[ch] == IDLE) ? avail_in : '0;
      assign avail_out = avail_in & ~grant;

      pmem_rr_picker #(
         .NUM_CONSUMERS(NUM_CONSUMERS)
      ) u_picker (
         .mask (mask),
         .start(rr_ptr_q),
         .grant(grant),
         .found(found)
      );

      always_comb begin
         idx = '0;
         for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (grant[c]) idx = IDX_BITS'(c);
         end
      end

      assign pick_found[ch]   = found;
      assign pick_idx[ch]     = idx;
      assign channel_busy[ch] = (state_q[ch] != IDLE);
   end

   // The highest-indexed granting channel holds the furthest pick in scan order.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (pick_found[ch]) begin
            rr_ptr_d = (pick_idx[ch] == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                     : pick_idx[ch] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q     <= '0;
         mem_valid_q  <= '0;
         mem_addr_q   <= '0;
         cons_ready_q <= '0;
         cons_data_q  <= '0;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            owner_q[ch] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            unique case (state_q[ch])
               IDLE: begin
                  if (pick_found[ch]) begin
                     owner_q[ch]     <= pick_idx[ch];
                     mem_addr_q[ch]  <= consumer_read_address[pick_idx[ch]];
                     mem_valid_q[ch] <= 1'b1;
                     state_q[ch]     <= REQUEST;
                  end
               end
               REQUEST: begin
                  if (mem_read_ready[ch]) begin
                     mem_valid_q[ch]              <= 1'b0;
                     cons_data_q[owner_q[ch]]  <= mem_read_data[ch];
                     cons_ready_q[owner_q[ch]] <= 1'b1;
                     state_q[ch]                  <= RELAY;
                  end
               end
               RELAY: begin
                  if (!consumer_read_valid[owner_q[ch]]) begin
                     cons_ready_q[owner_q[ch]] <= 1'b0;
                     cons_data_q[owner_q[ch]]  <= '0;
                     state_q[ch]                  <= DRAIN;
                  end
               end
               DRAIN: begin
                  // Wait out a stale ready so it is never taken as the next ack.
                  if (!mem_read_ready[ch]) state_q[ch] <= IDLE;
               end
            endcase
         end
      end
   end

   assign consumer_read_ready = cons_ready_q;
   assign consumer_read_data  = cons_data_q;
   assign mem_read_valid      = mem_valid_q;
   assign mem_read_address    = mem_addr_q;

endmodule
